// File: rtl/rom_read_pkg.sv
// Shared definitions for the ROM read controller: FSM encoding and width helpers.
package rom_read_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StIssue = ISSUE,
    StDrain = DRAIN
  } state_e;

  // Bits needed to index n items; never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while (((n - 1) >> w) != 0) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Tag shift register that tracks which ROM output cycles carry requested words.
module valid_delay_line #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic tag_in,
  output logic tail,
  output logic any_set
);

  logic [DEPTH-1:0] stages_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stages_q <= '0;
    end else begin
      stages_q <= {stages_q[DEPTH-2:0], tag_in};
    end
  end

  assign tail    = stages_q[DEPTH-1];
  assign any_set = |stages_q;

endmodule

// File: rtl/rom_read_controller.sv
// Pipelined single/burst reader for a bank of fixed-latency synchronous ROMs.
module rom_read_controller
  import rom_read_pkg::*;
#(
  parameter  int unsigned NUM_ROMS    = 4,
  parameter  int unsigned ADDR_WIDTH  = 8,
  parameter  int unsigned DATA_WIDTH  = 16,
  parameter  int unsigned ROM_LATENCY = 2,
  parameter  int unsigned BURST_WIDTH = 4,
  localparam int unsigned SEL_WIDTH   = clog2(NUM_ROMS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           req,
  input  logic [SEL_WIDTH-1:0]           rom_sel,
  input  logic [ADDR_WIDTH-1:0]          rom_addr,
  input  logic [BURST_WIDTH-1:0]         burst_len,
  output logic [ADDR_WIDTH-1:0]          rom_addr_out,
  input  logic [NUM_ROMS*DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           data_valid,
  output logic                           done,
  output logic                           busy,
  output logic                           sel_error
);

  state_e                 state_q;
  logic [SEL_WIDTH-1:0]   sel_q;
  logic [BURST_WIDTH-1:0] remaining_q;
  logic [BURST_WIDTH-1:0] out_left_q;
  logic                   sel_ok;
  logic                   push;
  logic                   tail;
  logic                   any_set;
  logic [DATA_WIDTH-1:0]  rom_word;

  always_comb begin
    sel_ok   = 32'(rom_sel) < NUM_ROMS;
    push     = (state_q == StIssue) || ((state_q == StIdle) && req && sel_ok);
    rom_word = rom_q[sel_q*DATA_WIDTH +: DATA_WIDTH];
  end

  valid_delay_line #(
    .DEPTH(ROM_LATENCY + 1)
  ) u_delay (
    .clock  (clock),
    .reset  (reset),
    .tag_in (push),
    .tail   (tail),
    .any_set(any_set)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      remaining_q  <= '0;
      out_left_q   <= '0;
      rom_addr_out <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      sel_error    <= 1'b0;
    end else begin
      sel_error  <= 1'b0;
      done       <= 1'b0;
      data_valid <= tail;
      // out_left_q counts words still to be delivered, so the last one raises done.
      if (tail) begin
        data_out   <= rom_word;
        done       <= (out_left_q == '0);
        out_left_q <= out_left_q - 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (req) begin
            if (sel_ok) begin
              sel_q        <= rom_sel;
              rom_addr_out <= rom_addr;
              remaining_q  <= burst_len;
              out_left_q   <= burst_len;
              busy         <= 1'b1;
              state_q      <= (burst_len != '0) ? StIssue : StDrain;
            end else begin
              sel_error <= 1'b1;
            end
          end
        end
        StIssue: begin
          rom_addr_out <= rom_addr_out + 1'b1;
          remaining_q  <= remaining_q - 1'b1;
          if (remaining_q == BURST_WIDTH'(1)) state_q <= StDrain;
        end
        StDrain: begin
          if (!any_set) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_read_controller.sv
// Randomised scoreboard bench for rom_read_controller plus a small second instance for edge cases.
module tb_rom_read_controller;

  localparam int unsigned NR   = 4;
  localparam int unsigned LAT  = 2;
  localparam int unsigned NR3  = 3;
  localparam int unsigned LAT3 = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        req;
  logic [1:0]  rom_sel;
  logic [7:0]  rom_addr;
  logic [3:0]  burst_len;
  logic [7:0]  rom_addr_out;
  logic [63:0] rom_q;
  logic [15:0] data_out;
  logic        data_valid, done, busy, sel_error;

  logic        req3;
  logic [1:0]  sel3;
  logic [7:0]  addr3;
  logic [3:0]  len3;
  logic [7:0]  rom_addr_out3;
  logic [47:0] rom_q3;
  logic [15:0] data_out3;
  logic        data_valid3, done3, busy3, sel_error3;

  rom_read_controller u_dut (
    .clock(clock), .reset(reset), .req(req), .rom_sel(rom_sel), .rom_addr(rom_addr),
    .burst_len(burst_len), .rom_addr_out(rom_addr_out), .rom_q(rom_q), .data_out(data_out),
    .data_valid(data_valid), .done(done), .busy(busy), .sel_error(sel_error)
  );

  rom_read_controller #(.NUM_ROMS(NR3), .ROM_LATENCY(LAT3)) u_dut3 (
    .clock(clock), .reset(reset), .req(req3), .rom_sel(sel3), .rom_addr(addr3),
    .burst_len(len3), .rom_addr_out(rom_addr_out3), .rom_q(rom_q3), .data_out(data_out3),
    .data_valid(data_valid3), .done(done3), .busy(busy3), .sel_error(sel_error3)
  );

  function automatic logic [15:0] rom_word(input int i, input logic [7:0] a);
    logic [15:0] key;
    case (i)
      0:       key = 16'h1111;
      1:       key = 16'h5A5A;
      2:       key = 16'hA5A5;
      default: key = 16'hC3C3;
    endcase
    return {8'h00, a} ^ key;
  endfunction

  // ROM bank models: q reflects the address presented LAT clocks earlier.
  logic [7:0] ap  [0:LAT-1];
  logic [7:0] ap3 [0:LAT3-1];
  always @(posedge clock) begin
    ap[0] <= rom_addr_out;
    for (int i = 1; i < LAT; i++) ap[i] <= ap[i-1];
    ap3[0] <= rom_addr_out3;
    for (int i = 1; i < LAT3; i++) ap3[i] <= ap3[i-1];
  end
  always_comb begin
    rom_q  = '0;
    rom_q3 = '0;
    for (int i = 0; i < NR; i++) rom_q[i*16 +: 16] = rom_word(i, ap[LAT-1]);
    for (int i = 0; i < NR3; i++) rom_q3[i*16 +: 16] = rom_word(i, ap3[LAT3-1]);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  typedef struct packed {
    int          cyc;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   cyc       = 0;
  int   free_edge = 1;
  int   busy_lo   = 1;
  int   busy_hi   = 0;
  int   err_cyc   = -1;
  bit   chk_en    = 1'b0;

  // Reference model: an accepted burst of N words yields word k after edge e+LAT+1+k,
  // busy covers edges e..e+N+LAT, and the next acceptance is possible two edges later.
  task automatic step(input logic r, input logic [1:0] s, input logic [7:0] a,
                      input logic [3:0] l);
    @(negedge clock);
    req = r; rom_sel = s; rom_addr = a; burst_len = l;
    @(posedge clock);
    cyc++;
    if (r && cyc >= free_edge) begin
      if (32'(s) < NR) begin
        for (int k = 0; k <= int'(l); k++)
          exp_q.push_back('{cyc: cyc + LAT + 1 + k, data: rom_word(int'(s), a + 8'(k)),
                            last: (k == int'(l))});
        busy_lo   = cyc;
        busy_hi   = cyc + int'(l) + 1 + LAT;
        free_edge = busy_hi + 2;
      end else begin
        err_cyc = cyc;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'($urandom), 8'($urandom), 4'($urandom));
  endtask

  always @(negedge clock) begin : monitor
    logic ev;
    exp_t it;
    if (chk_en) begin
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      check("sel_error", 32'(sel_error), 32'(cyc == err_cyc));
      check("data_valid", 32'(data_valid), 32'(ev));
      if (ev) begin
        it = exp_q.pop_front();
        if (data_valid) begin
          check("data_out", 32'(data_out), 32'(it.data));
          check("done", 32'(done), 32'(it.last));
        end
      end else begin
        check("done_idle", 32'(done), 32'd0);
      end
    end
  end

  initial begin
    int e0, first, nvalid, gaps, busycnt, done_t;
    logic [7:0] a;
    logic [3:0] l;
    req = 0; rom_sel = 0; rom_addr = 0; burst_len = 0;
    req3 = 0; sel3 = 0; addr3 = 0; len3 = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(rom_addr_out), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_sel_error", 32'(sel_error), 0);
    repeat (2) @(negedge clock);
    reset  = 1'b1;
    chk_en = 1'b1;

    step(1'b1, 2'd2, 8'h10, 4'd0);
    idle(6);
    step(1'b1, 2'd1, 8'hFE, 4'd3);
    idle(8);
    // Request held high with a wandering address: only IDLE-cycle samples may start bursts.
    repeat (14) step(1'b1, 2'd0, 8'($urandom), 4'd1);
    idle(6);
    repeat (400) begin
      a = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a = a | 8'hF8;
      l = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, 2'($urandom), a, l);
    end
    idle(25);
    check("queue_drained", 32'(exp_q.size()), 0);

    step(1'b1, 2'd3, 8'h40, 4'hF);
    e0 = cyc;
    while (cyc < e0 + LAT + 2) idle(1);
    #2 reset = 1'b0;
    #1;
    chk_en = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(data_valid), 0);
    check("abort_done", 32'(done), 0);
    check("abort_addr", 32'(rom_addr_out), 0);
    check("abort_data", 32'(data_out), 0);
    exp_q.delete();
    busy_lo = 1; busy_hi = 0; err_cyc = -1;
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    free_edge = cyc + 1;
    chk_en    = 1'b1;
    idle(8);
    step(1'b1, 2'd0, 8'h33, 4'd2);
    idle(8);
    check("queue_drained_2", 32'(exp_q.size()), 0);
    chk_en = 1'b0;

    @(negedge clock);
    req3 = 1'b1; sel3 = 2'd3; addr3 = 8'h77; len3 = 4'd0;
    @(posedge clock); #1;
    check("sel3_error", 32'(sel_error3), 1);
    check("sel3_busy", 32'(busy3), 0);
    check("sel3_valid", 32'(data_valid3), 0);
    check("sel3_addr", 32'(rom_addr_out3), 0);
    @(negedge clock); req3 = 1'b0;
    @(posedge clock); #1;
    check("sel3_pulse", 32'(sel_error3), 0);

    @(negedge clock);
    req3 = 1'b1; sel3 = 2'd2; addr3 = 8'hF8; len3 = 4'hF;
    @(posedge clock); #1;
    req3 = 1'b0;
    first = -1; nvalid = 0; gaps = 0; busycnt = 0; done_t = -1;
    for (int t = 0; t < 40; t++) begin
      if (busy3) busycnt++;
      if (data_valid3) begin
        if (first < 0) first = t;
        if (t != first + nvalid) gaps++;
        check("lat4_data", 32'(data_out3), 32'(rom_word(2, 8'(8'hF8 + 8'(nvalid)))));
        nvalid++;
      end
      if (done3) done_t = t;
      @(posedge clock); #1;
    end
    check("lat4_first", 32'(first), LAT3 + 1);
    check("lat4_words", 32'(nvalid), 16);
    check("lat4_gaps", 32'(gaps), 0);
    check("lat4_busy", 32'(busycnt), 16 + LAT3 + 1);
    check("lat4_done", 32'(done_t), LAT3 + 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
